dt_forest_engine: RTL and testbench

Sequential, table-driven decision-forest classifier replacing fixed, hard-wired mux-tree classifiers. Node tables are loaded at runtime through a config port. The engine walks N_TREES trees, one node per cycle, over a latched binary feature vector, then takes a majority vote. Sits between the feature-extraction front end and the result consumer, with valid/ready handshakes on both sides.

---
 rtl/dt_forest_engine_if.sv | 38 +++
 rtl/dt_forest_engine.sv | 149 ++++++++++++++
 tb/tb_dt_forest_engine.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dt_forest_engine_if.sv
// Handshake and configuration bundle for dt_forest_engine.
// The master side is the front end plus the result consumer; the slave side is the engine.
interface dt_forest_engine_if #(
  parameter int N_FEAT  = 51,
  parameter int N_TREES = 4,
  parameter int N_NODES = 64,
  parameter int CLS_W   = 2
);
  localparam int FIDX_W = $clog2(N_FEAT);
  localparam int NIDX_W = $clog2(N_NODES);
  localparam int TIDX_W = (N_TREES > 1) ? $clog2(N_TREES) : 1;
  localparam int NODE_W = 1 + FIDX_W + 2 * NIDX_W + CLS_W;
  localparam int VOTE_W = $clog2(N_TREES + 1);

  logic              cfg_we;
  logic [TIDX_W-1:0] cfg_tree;
  logic [NIDX_W-1:0] cfg_addr;
  logic [NODE_W-1:0] cfg_wdata;
  logic              cfg_ready;
  logic              in_valid;
  logic              in_ready;
  logic [N_FEAT-1:0] in_feat;
  logic              out_valid;
  logic              out_ready;
  logic [CLS_W-1:0]  out_cls;
  logic [VOTE_W-1:0] out_votes;
  logic              out_err;

  modport master (
    output cfg_we, cfg_tree, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
    input  cfg_ready, in_ready, out_valid, out_cls, out_votes, out_err
  );

  modport slave (
    input  cfg_we, cfg_tree, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
    output cfg_ready, in_ready, out_valid, out_cls, out_votes, out_err
  );
endinterface

// File: rtl/dt_forest_engine.sv
// Table-driven decision-forest classifier: walks each tree one node per cycle
// over a latched feature vector, then reports the majority class.
module dt_forest_engine #(
  parameter int N_FEAT    = 51,
  parameter int N_TREES   = 4,
  parameter int N_NODES   = 64,
  parameter int CLS_W     = 2,
  parameter int MAX_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dt_forest_engine_if.slave bus
);
  localparam int FIDX_W  = $clog2(N_FEAT);
  localparam int NIDX_W  = $clog2(N_NODES);
  localparam int TIDX_W  = (N_TREES > 1) ? $clog2(N_TREES) : 1;
  localparam int NODE_W  = 1 + FIDX_W + 2 * NIDX_W + CLS_W;
  localparam int NC      = 2 ** CLS_W;
  localparam int VOTE_W  = $clog2(N_TREES + 1);
  localparam int DEPTH_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_VOTE, S_OUT} state_t;

  state_t              r_state, w_state_next;
  logic [NODE_W-1:0]   r_table [N_TREES*N_NODES];
  logic [N_FEAT-1:0]   r_feat;
  logic [TIDX_W-1:0]   r_tree;
  logic [NIDX_W-1:0]   r_node;
  logic [DEPTH_W-1:0]  r_depth;
  logic                r_err;
  logic [VOTE_W-1:0]   r_votes [NC];
  logic [CLS_W-1:0]    r_out_cls;
  logic [VOTE_W-1:0]   r_out_votes;
  logic                r_out_err;

  logic                w_cfg_wr, w_accept, w_walk;
  logic [NODE_W-1:0]   w_node;
  logic                w_leaf, w_bit, w_guard, w_tree_done, w_last_tree;
  logic [FIDX_W-1:0]   w_fidx;
  logic [NIDX_W-1:0]   w_true, w_false;
  logic [CLS_W-1:0]    w_cls, w_vote_cls, w_best_cls;
  logic [VOTE_W-1:0]   w_best_votes;

  assign w_cfg_wr = bus.cfg_we && (r_state == S_IDLE);
  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_walk   = (r_state == S_WALK);

  // Node storage has no reset so a loaded forest survives rst_n.
  always_ff @(posedge clk) begin
    if (w_cfg_wr)
      r_table[{bus.cfg_tree, bus.cfg_addr}] <= bus.cfg_wdata;
  end

  assign w_node = r_table[{r_tree, r_node}];
  assign {w_leaf, w_fidx, w_true, w_false, w_cls} = w_node;
  assign w_bit       = (32'(w_fidx) < N_FEAT) ? r_feat[w_fidx] : 1'b0;
  assign w_guard     = !w_leaf && (r_depth == DEPTH_W'(MAX_DEPTH - 1));
  assign w_tree_done = w_leaf || w_guard;
  assign w_vote_cls  = w_leaf ? w_cls : '0;
  assign w_last_tree = (r_tree == TIDX_W'(N_TREES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)                w_state_next = S_WALK;
      S_WALK:  if (w_tree_done && w_last_tree)  w_state_next = S_VOTE;
      S_VOTE:                                   w_state_next = S_OUT;
      S_OUT:   if (bus.out_ready)               w_state_next = S_IDLE;
      default:                                  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.cfg_ready = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_OUT);
    bus.out_cls   = r_out_cls;
    bus.out_votes = r_out_votes;
    bus.out_err   = r_out_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feat  <= '0;
      r_tree  <= '0;
      r_node  <= '0;
      r_depth <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_feat  <= bus.in_feat;
      r_tree  <= '0;
      r_node  <= '0;
      r_depth <= '0;
      r_err   <= 1'b0;
    end else if (w_walk) begin
      if (w_tree_done) begin
        r_tree  <= r_tree + 1'b1;
        r_node  <= '0;
        r_depth <= '0;
        if (w_guard) r_err <= 1'b1;
      end else begin
        r_node  <= w_bit ? w_true : w_false;
        r_depth <= r_depth + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NC; gi++) begin : g_vote
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_votes[gi] <= '0;
        else if (w_accept)
          r_votes[gi] <= '0;
        else if (w_walk && w_tree_done && (w_vote_cls == CLS_W'(gi)))
          r_votes[gi] <= r_votes[gi] + 1'b1;
      end
    end
  endgenerate

  // Strict '>' keeps the lowest class index on a tie.
  always_comb begin
    w_best_cls   = '0;
    w_best_votes = r_votes[0];
    for (int c = 1; c < NC; c++) begin
      if (r_votes[c] > w_best_votes) begin
        w_best_cls   = CLS_W'(c);
        w_best_votes = r_votes[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cls   <= '0;
      r_out_votes <= '0;
      r_out_err   <= 1'b0;
    end else if (r_state == S_VOTE) begin
      r_out_cls   <= w_best_cls;
      r_out_votes <= w_best_votes;
      r_out_err   <= r_err;
    end
  end
endmodule

// File: tb/tb_dt_forest_engine.sv
// Directed bench for dt_forest_engine: a tree-walking reference model predicts
// class, votes, error flag and latency for every vector.
module tb_dt_forest_engine;
  localparam int N_FEAT    = 51;
  localparam int N_TREES   = 4;
  localparam int N_NODES   = 64;
  localparam int CLS_W     = 2;
  localparam int MAX_DEPTH = 16;
  localparam int NC        = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dt_forest_engine_if #(.N_FEAT(N_FEAT), .N_TREES(N_TREES), .N_NODES(N_NODES), .CLS_W(CLS_W)) bus();

  dt_forest_engine #(
    .N_FEAT(N_FEAT), .N_TREES(N_TREES), .N_NODES(N_NODES), .CLS_W(CLS_W), .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [20:0] m_tbl [N_TREES][N_NODES];
  int          exp_cls, exp_votes, exp_err, exp_lat;
  bit          exp_armed = 1'b0;
  logic [50:0] fv;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [20:0] nd(input int leaf, input int fi, input int tc, input int fc, input int cls);
    return {1'(leaf), 6'(fi), 6'(tc), 6'(fc), 2'(cls)};
  endfunction

  // Walk each tree from its root, at most MAX_DEPTH nodes; a tree that never
  // reaches a leaf votes class 0 and flags an error.
  function automatic void model(input logic [N_FEAT-1:0] f, output int cls, output int votes,
                                output int err, output int cycles);
    int          v [NC];
    int          node;
    int          fi;
    bit          done;
    logic [20:0] w;
    for (int c = 0; c < NC; c++) v[c] = 0;
    err = 0;
    cycles = 0;
    for (int t = 0; t < N_TREES; t++) begin
      node = 0;
      done = 1'b0;
      for (int d = 0; d < MAX_DEPTH && !done; d++) begin
        w = m_tbl[t][node];
        cycles++;
        if (w[20]) begin
          v[int'(w[1:0])]++;
          done = 1'b1;
        end else begin
          fi = int'(w[19:14]);
          node = (fi < N_FEAT && f[fi] == 1'b1) ? int'(w[13:8]) : int'(w[7:2]);
        end
      end
      if (!done) begin
        v[0]++;
        err = 1;
      end
    end
    cls = 0;
    votes = v[0];
    for (int c = 1; c < NC; c++) begin
      if (v[c] > votes) begin
        cls = c;
        votes = v[c];
      end
    end
  endfunction

  task automatic wr(input int t, input int a, input logic [20:0] w);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_tree  = 2'(t);
    bus.cfg_addr  = 6'(a);
    bus.cfg_wdata = w;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    m_tbl[t][a]   = w;
  endtask

  task automatic run_vec(input string name, input logic [50:0] f, input int hc, input int hv,
                         input int he, input int hl, input int hold, input bit walk_wr);
    int cyc;
    model(f, exp_cls, exp_votes, exp_err, exp_lat);
    exp_lat = exp_lat + 1;
    chk({name, " model_cls"},   exp_cls,   hc);
    chk({name, " model_votes"}, exp_votes, hv);
    chk({name, " model_err"},   exp_err,   he);
    exp_armed = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!bus.in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " in_ready_idle"}, int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_feat  = f;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk({name, " in_ready_busy"}, int'(bus.in_ready), 0);
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      if (walk_wr && cyc == 1) begin
        bus.cfg_we    = 1'b1;
        bus.cfg_tree  = 2'd3;
        bus.cfg_addr  = 6'd0;
        bus.cfg_wdata = nd(1, 0, 0, 0, 0);
        chk({name, " cfg_ready_walk"}, int'(bus.cfg_ready), 0);
      end else begin
        bus.cfg_we = 1'b0;
      end
      @(posedge clk);
      #1 cyc++;
    end
    bus.cfg_we = 1'b0;
    chk({name, " latency"}, cyc, exp_lat);
    chk({name, " latency_hand"}, cyc, hl);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk({name, " out_valid_after_hs"}, int'(bus.out_valid), 0);
    chk({name, " in_ready_after_hs"},  int'(bus.in_ready), 1);
    exp_armed = 1'b0;
    $display("txn %s: cls=%0d votes=%0d err=%0d latency=%0d", name, exp_cls, exp_votes, exp_err, cyc);
  endtask

  // Every cycle a result is presented it must match the model and hold off new input.
  always @(negedge clk) begin
    if (rst_n && exp_armed && bus.out_valid) begin
      chk("out_cls",       int'(bus.out_cls),   exp_cls);
      chk("out_votes",     int'(bus.out_votes), exp_votes);
      chk("out_err",       int'(bus.out_err),   exp_err);
      chk("in_ready_out",  int'(bus.in_ready),  0);
      chk("cfg_ready_out", int'(bus.cfg_ready), 0);
    end
  end

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_tree  = '0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.in_valid  = 1'b0;
    bus.in_feat   = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst in_ready",  int'(bus.in_ready),  1);
    chk("rst cfg_ready", int'(bus.cfg_ready), 1);
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst out_cls",   int'(bus.out_cls),   0);
    chk("rst out_votes", int'(bus.out_votes), 0);
    chk("rst out_err",   int'(bus.out_err),   0);
    rst_n = 1'b1;

    for (int t = 0; t < N_TREES; t++) wr(t, 0, nd(1, 0, 0, 0, 2));
    fv = 51'h5_A5A5_1234_C3C3;
    run_vec("all_leaf", fv, 2, 4, 0, 5, 0, 1'b0);

    wr(0, 0, nd(0, 7, 1, 2, 0));
    wr(0, 1, nd(1, 0, 0, 0, 1));
    wr(0, 2, nd(1, 0, 0, 0, 3));
    for (int t = 1; t < N_TREES; t++) wr(t, 0, nd(1, 0, 0, 0, 1));
    fv = '0;
    fv[7] = 1'b1;
    run_vec("f7_one_hold", fv, 1, 4, 0, 6, 10, 1'b1);
    run_vec("f7_one_rerun", fv, 1, 4, 0, 6, 0, 1'b0);
    fv = '1;
    fv[7] = 1'b0;
    run_vec("f7_zero", fv, 1, 3, 0, 6, 0, 1'b0);

    wr(1, 0, nd(1, 0, 0, 0, 3));
    run_vec("tie_3_vs_1", fv, 1, 2, 0, 6, 0, 1'b0);

    wr(0, 0, nd(1, 0, 0, 0, 2));
    wr(1, 0, nd(1, 0, 0, 0, 2));
    wr(3, 0, nd(1, 0, 0, 0, 2));
    wr(2, 0, nd(0, 3, 0, 0, 0));
    fv = 51'h1_0F0F_5555_AAAA;
    run_vec("self_loop", fv, 2, 3, 1, 20, 0, 1'b0);

    exp_armed = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_feat  = fv;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("prerst in_ready", int'(bus.in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", int'(bus.out_valid), 0);
    chk("midrst in_ready",  int'(bus.in_ready),  1);
    chk("midrst cfg_ready", int'(bus.cfg_ready), 1);
    chk("midrst out_cls",   int'(bus.out_cls),   0);
    chk("midrst out_votes", int'(bus.out_votes), 0);
    chk("midrst out_err",   int'(bus.out_err),   0);
    $display("txn mid_walk_reset: in_ready=%0d out_valid=%0d", bus.in_ready, bus.out_valid);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_reset", fv, 2, 3, 1, 20, 0, 1'b0);

    for (int i = 0; i < 15; i++) wr(0, i, nd(0, i, i + 1, i + 1, 0));
    wr(0, 15, nd(1, 0, 0, 0, 3));
    for (int i = 0; i < 16; i++) wr(1, i, nd(0, i, i + 1, i + 1, 0));
    wr(1, 16, nd(1, 0, 0, 0, 3));
    wr(2, 0, nd(1, 0, 0, 0, 3));
    wr(3, 0, nd(1, 0, 0, 0, 3));
    fv = 51'h2_3456_789A_BCDE;
    run_vec("depth_edge", fv, 3, 3, 1, 35, 0, 1'b0);

    wr(0, 0, nd(0, 60, 1, 2, 0));
    wr(0, 1, nd(1, 0, 0, 0, 3));
    wr(0, 2, nd(1, 0, 0, 0, 0));
    wr(1, 0, nd(1, 0, 0, 0, 3));
    wr(2, 0, nd(1, 0, 0, 0, 3));
    wr(3, 0, nd(0, 50, 1, 2, 0));
    wr(3, 1, nd(1, 0, 0, 0, 0));
    wr(3, 2, nd(1, 0, 0, 0, 3));
    fv = '1;
    run_vec("fidx_range", fv, 0, 2, 0, 7, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
